// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port synchronous memory, with bounded burst lock.
// Latency: grant is combinational (0 cycles); read data and rvalid arrive 1 cycle after the grant.
// Backpressure: a requester holds req until gnt; a losing port simply waits, and nothing is queued.
//
// Ports: clk/rst (sync, active-high); per-port req/we/lock/addr/wdata in, gnt/rvalid out;
//        rd_data shared return; mem_* drive the memory command and mem_data_out brings its read data back.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_WIDTH  = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [MEM_WIDTH-1:0]  wdata0,
    input  logic [MEM_WIDTH-1:0]  wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [MEM_WIDTH-1:0]  rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [MEM_WIDTH-1:0]  mem_data_in,
    input  logic [MEM_WIDTH-1:0]  mem_data_out
);

    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    // A locked beat may extend the lock only while beats+1 < MAX_BURST,
    // i.e. beats < MAX_BURST-1. With MAX_BURST=1 this never holds, so lock is inert.
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          prio;
    logic          prio_nxt;
    logic [BW-1:0] beats;
    logic [BW-1:0] beats_nxt;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic          arb_prio;
    logic          g0;
    logic          g1;

    // Grant selection. A lock owner that drops its request releases ownership
    // in the same cycle, and the other port is then preferred.
    always_comb begin
        g0       = 1'b0;
        g1       = 1'b0;
        arb_prio = prio;
        if (!rst) begin
            if (state == LOCK0 && req0) begin
                g0 = 1'b1;
            end else if (state == LOCK1 && req1) begin
                g1 = 1'b1;
            end else begin
                if (state == LOCK0) begin
                    arb_prio = 1'b1;
                end else if (state == LOCK1) begin
                    arb_prio = 1'b0;
                end
                if (req0 && req1) begin
                    g0 = ~arb_prio;
                    g1 = arb_prio;
                end else begin
                    g0 = req0;
                    g1 = req1;
                end
            end
        end
    end

    // Ownership / burst bookkeeping after the beat granted this cycle.
    always_comb begin
        state_nxt = IDLE;
        beats_nxt = '0;
        prio_nxt  = arb_prio;
        if (g0) begin
            if (lock0 && beats < LAST_BEAT) begin
                state_nxt = LOCK0;
                beats_nxt = beats + 1'b1;
            end else begin
                prio_nxt = 1'b1;
            end
        end else if (g1) begin
            if (lock1 && beats < LAST_BEAT) begin
                state_nxt = LOCK1;
                beats_nxt = beats + 1'b1;
            end else begin
                prio_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            beats     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            prio      <= prio_nxt;
            beats     <= beats_nxt;
            rvalid0_q <= g0 & ~we0;
            rvalid1_q <= g1 & ~we1;
        end
    end

    // A read granted just before reset must not show up while reset is held,
    // so the registered valids are qualified by rst.
    assign rvalid0 = rvalid0_q & ~rst;
    assign rvalid1 = rvalid1_q & ~rst;

    assign gnt0        = g0;
    assign gnt1        = g1;
    assign rd_data     = mem_data_out;
    assign mem_wr_en   = (g0 & we0) | (g1 & we1);
    assign mem_address = g0 ? addr0  : (g1 ? addr1  : '0);
    assign mem_data_in = g0 ? wdata0 : (g1 ? wdata1 : '0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with a behavioural single-port memory.
// The driver pushes per-cycle expectations into a queue and a negedge monitor pops and compares them.
// Summary line reports total comparisons and mismatches.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [3:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rd_data;
    logic        mem_wr_en;
    logic [3:0]  mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    mem_arbiter #(.ADDR_WIDTH(4), .MEM_WIDTH(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rd_data(rd_data), .mem_wr_en(mem_wr_en), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: registered read, write-or-read per cycle; contents reload on reset.
    logic [15:0] mem [16];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
        end else if (mem_wr_en) begin
            mem[mem_address] <= mem_data_in;
        end else begin
            mem_data_out <= mem[mem_address];
        end
    end

    typedef struct {
        logic        g0;
        logic        g1;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] din;
        logic        rv0;
        logic        rv1;
        logic [15:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    logic        pend0   = 1'b0;
    logic        pend1   = 1'b0;
    logic [15:0] pend_rd = 16'h0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
        end
    endtask

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            chk("gnt0",        16'(gnt0),      16'(e.g0));
            chk("gnt1",        16'(gnt1),      16'(e.g1));
            chk("mem_wr_en",   16'(mem_wr_en), 16'(e.wr));
            chk("mem_address", 16'(mem_address), 16'(e.addr));
            chk("mem_data_in", mem_data_in,    e.din);
            chk("rvalid0",     16'(rvalid0),   16'(e.rv0));
            chk("rvalid1",     16'(rvalid1),   16'(e.rv1));
            if (e.rv0 || e.rv1) chk("rd_data", rd_data, e.rd);
        end
    end

    // p = {req, we, lock}; eg = {gnt1, gnt0} expected this cycle; erd = data the granted read returns.
    task automatic step(input logic rs,
                        input logic [2:0] p0, input logic [3:0] a0, input logic [15:0] d0,
                        input logic [2:0] p1, input logic [3:0] a1, input logic [15:0] d1,
                        input logic [1:0] eg, input logic [15:0] erd);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rs;
        {req0, we0, lock0} = p0;
        {req1, we1, lock1} = p1;
        addr0 = a0; wdata0 = d0;
        addr1 = a1; wdata1 = d1;
        e.g0   = eg[0];
        e.g1   = eg[1];
        e.wr   = (eg[0] & p0[1]) | (eg[1] & p1[1]);
        e.addr = eg[0] ? a0 : (eg[1] ? a1 : 4'h0);
        e.din  = eg[0] ? d0 : (eg[1] ? d1 : 16'h0);
        e.rv0  = pend0 & ~rs;
        e.rv1  = pend1 & ~rs;
        e.rd   = pend_rd;
        exp_q.push_back(e);
        pend0   = eg[0] & ~p0[1];
        pend1   = eg[1] & ~p1[1];
        pend_rd = erd;
    endtask

    localparam logic [2:0] N  = 3'b000;
    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] RL = 3'b101;
    localparam logic [2:0] W  = 3'b110;

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 16'h0; wdata1 = 16'h0;

        // Reset: grants masked even with a request present.
        step(1, R, 4'd1, 16'h0, N, 4'd0, 16'h0, 2'b00, 16'h0);
        step(1, N, 4'd0, 16'h0, N, 4'd0, 16'h0, 2'b00, 16'h0);
        // Idle for 5 cycles.
        for (int i = 0; i < 5; i++) step(0, N, 4'd0, 16'h0, N, 4'd0, 16'h0, 2'b00, 16'h0);

        // Port0 writes BEEF to addr 3, then port1 reads it back.
        step(0, W, 4'd3, 16'hBEEF, N, 4'd0, 16'h0, 2'b01, 16'h0);
        step(0, N, 4'd0, 16'h0,    R, 4'd3, 16'h0, 2'b10, 16'hBEEF);
        step(0, N, 4'd0, 16'h0,    N, 4'd0, 16'h0, 2'b00, 16'h0);

        // Reset, then both read continuously without lock: 0,1,0,1.
        step(1, N, 4'd0, 16'h0, N, 4'd0, 16'h0, 2'b00, 16'h0);
        step(0, R, 4'd5, 16'h0, R, 4'd6, 16'h0, 2'b01, 16'hA005);
        step(0, R, 4'd5, 16'h0, R, 4'd6, 16'h0, 2'b10, 16'hA006);
        step(0, R, 4'd5, 16'h0, R, 4'd6, 16'h0, 2'b01, 16'hA005);
        step(0, R, 4'd5, 16'h0, R, 4'd6, 16'h0, 2'b10, 16'hA006);
        step(0, N, 4'd0, 16'h0, N, 4'd0, 16'h0, 2'b00, 16'h0);

        // Port0 locked for 6 beats against continuous port1: 0,0,0,0,1,0,0.
        step(0, RL, 4'd1, 16'h0, R, 4'd2, 16'h0, 2'b01, 16'hA001);
        step(0, RL, 4'd1, 16'h0, R, 4'd2, 16'h0, 2'b01, 16'hA001);
        step(0, RL, 4'd1, 16'h0, R, 4'd2, 16'h0, 2'b01, 16'hA001);
        step(0, RL, 4'd1, 16'h0, R, 4'd2, 16'h0, 2'b01, 16'hA001);
        step(0, RL, 4'd1, 16'h0, R, 4'd2, 16'h0, 2'b10, 16'hA002);
        step(0, RL, 4'd1, 16'h0, R, 4'd2, 16'h0, 2'b01, 16'hA001);
        step(0, RL, 4'd1, 16'h0, R, 4'd2, 16'h0, 2'b01, 16'hA001);
        // Port0 holds lock with beats=2 and drops req: port1 wins the same cycle.
        step(0, N,  4'd0, 16'h0, R, 4'd2, 16'h0, 2'b10, 16'hA002);
        // Released to IDLE with prio back on port0.
        step(0, R,  4'd7, 16'h0, R, 4'd8, 16'h0, 2'b01, 16'hA007);
        step(0, N,  4'd0, 16'h0, N, 4'd0, 16'h0, 2'b00, 16'h0);

        // Locked read by port1, then reset: no rvalid in the reset cycle, lock abandoned.
        step(0, N, 4'd0,  16'h0, RL, 4'd10, 16'h0, 2'b10, 16'hA00A);
        step(1, R, 4'd11, 16'h0, RL, 4'd10, 16'h0, 2'b00, 16'h0);
        step(0, R, 4'd11, 16'h0, RL, 4'd10, 16'h0, 2'b01, 16'hA00B);
        step(0, N, 4'd0,  16'h0, N,  4'd0,  16'h0, 2'b00, 16'h0);
        step(0, N, 4'd0,  16'h0, N,  4'd0,  16'h0, 2'b00, 16'h0);

        // Let the monitor drain, then confirm nothing was left unchecked.
        repeat (2) @(posedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the team's single-port synchronous memory block (registered read, write-or-read per cycle). It sits directly in front of the memory, merges two independent request ports into one command stream, and routes read data back with a per-port valid. Arbitration is round-robin with an optional bounded lock for back-to-back bursts.

## Interface
- ADDR_WIDTH, 4, memory address width
- MEM_WIDTH, 16, data word width
- MAX_BURST, 4, max consecutive beats one locked requester may hold the memory (≥1)

- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req0 / req1  input  1  request, held until granted
- we0 / we1  input  1  1 = write, 0 = read
- lock0 / lock1  input  1  ask to keep ownership on the next cycle
- addr0 / addr1  input  ADDR_WIDTH  access address
- wdata0 / wdata1  input  MEM_WIDTH  write data
- gnt0 / gnt1  output  1  combinational grant; the access completes on the edge ending this cycle
- rvalid0 / rvalid1  output  1  registered; rd_data valid for that port this cycle
- rd_data  output  MEM_WIDTH  shared read data, equal to mem_data_out
- mem_wr_en  output  1  to memory write enable
- mem_address  output  ADDR_WIDTH  to memory address
- mem_data_in  output  MEM_WIDTH  to memory write data
- mem_data_out  input  MEM_WIDTH  from memory read data

## Operation
- One access per cycle; at most one of gnt0/gnt1 is high.
- Command mux: granted port's addr/wdata drive mem_address/mem_data_in; mem_wr_en = granted & we. With no grant: mem_wr_en=0, mem_address=0, mem_data_in=0.
- State: owner FSM {IDLE, LOCK0, LOCK1}, 1-bit priority pointer `prio`, burst counter `beats` (0..MAX_BURST).
- IDLE: exactly one request → grant it; both → grant `prio`; none → no grant.
- After a granted beat by X:
  - If lockX=1 and beats+1 < MAX_BURST → LOCKX, beats += 1.
  - Otherwise → IDLE, beats=0, prio = other port.
- LOCKX: if reqX=1, grant X unconditionally, even if the other port is requesting, and apply the rule above. If reqX=0, ownership releases in the same cycle: arbitrate as IDLE with prio = other, and beats=0.
- Read return: a granted read sets rvalidX=1 for exactly the next cycle, and rd_data carries that read. Writes produce no rvalid. Non-granted cycles never raise rvalid, even though mem_data_out may change.
- A read and a write to the same address on consecutive cycles behave the same as the memory itself does; the arbiter adds no forwarding.

## Timing
- Reset (rst high at an edge): state=IDLE, prio=0, beats=0, rvalid0=rvalid1=0. While rst is high, gnt0=gnt1=0 and mem_wr_en=0.
- Reset mid-burst: the lock is abandoned. The first cycle after reset arbitrates from IDLE with prio=0. A read granted on the cycle before reset does not raise rvalid after reset.
- Grant latency: 0 cycles, so gnt is high in the same cycle as req when the port wins.
- Read latency: data appears 1 cycle after the grant cycle.
- Write: memory updated at the edge ending the grant cycle.
- Both requesters continuously active, no lock: grants alternate 0,1,0,1…, starting from prio.
- lock held continuously: at most MAX_BURST consecutive grants to one port, then the other port is granted if it is requesting.
- MAX_BURST=1: the lock has no effect; behaves as pure round-robin.

## Test plan
- Reset, then both ports idle → gnt0=gnt1=0, mem_wr_en=0, rvalid0=rvalid1=0 for 5 cycles.
- Port0 writes 0xBEEF to addr 3; next cycle port1 reads addr 3 → gnt1 in cycle 2, rvalid1=1 with rd_data=0xBEEF in cycle 3, rvalid0 stays 0.
- Both ports request reads continuously, no lock, after reset → gnt sequence 0,1,0,1. Each rvalid follows its grant by 1 cycle with the correct data.
- Port0 requests with lock0=1 for 6 beats and port1 requests continuously, MAX_BURST=4 → gnt0 for 4 cycles, then gnt1, then gnt0.
- Port0 locked (beats=2), drops req0 while port1 requests → gnt1 in that same cycle, and next IDLE prio=0.
- Read granted, then rst asserted on the next cycle → rvalid0=0 in and after the reset cycle. The first post-reset grant with both requesting goes to port0.
